// File: rtl/ppu_stream.sv
// Post-processing unit: per-row/per-lane scale, bias, optional ReLU, round/truncate and
// symmetric saturation over a streamed tile, with per-tile absolute-maximum reporting.
module ppu_stream #(
    parameter int LANES  = 16,
    parameter int ACC_W  = 24,
    parameter int COEF_W = 16,
    parameter int FRAC   = 10,
    parameter int OUT_W  = 18,
    parameter int ROWS   = 16,
    parameter int TILE_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_coef_we,
    input  logic                      i_coef_sel,
    input  logic [$clog2(ROWS)-1:0]   i_coef_addr,
    input  logic [LANES*COEF_W-1:0]   i_coef_data,
    input  logic                      i_start,
    input  logic [TILE_W-1:0]         i_num_tiles,
    input  logic                      i_relu_en,
    input  logic                      i_round_en,
    input  logic                      i_acc_valid,
    input  logic [LANES*ACC_W-1:0]    i_acc_data,
    output logic                      o_busy,
    output logic                      o_ready,
    output logic                      o_data_valid,
    output logic [LANES*OUT_W-1:0]    o_data,
    output logic [$clog2(ROWS)-1:0]   o_row_idx,
    output logic                      o_tile_done,
    output logic [OUT_W-2:0]          o_tile_absmax,
    output logic                      o_done
);

    localparam int RA = $clog2(ROWS);
    localparam int PW = COEF_W + ACC_W;
    localparam int SW = PW + 1;
    localparam logic [SW:0] HALF = (SW+1)'(64'd1 << (FRAC - 1));
    localparam logic [SW:0] SAT  = (SW+1)'((64'd1 << (OUT_W - 1)) - 64'd1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;

    logic [LANES*COEF_W-1:0] scale_mem [ROWS];
    logic [LANES*COEF_W-1:0] bias_mem  [ROWS];

    logic [TILE_W-1:0] num_tiles_q;
    logic              relu_q;
    logic              round_q;
    logic [RA-1:0]     row_cnt;
    logic [TILE_W-1:0] tile_cnt;

    logic start_ok, accept, row_last, tile_last;

    logic                     v1, tl1, dn1;
    logic [RA-1:0]            row1;
    logic signed [PW-1:0]     prod_c [LANES];
    logic signed [PW-1:0]     prod1  [LANES];
    logic signed [COEF_W-1:0] bias1  [LANES];

    logic                     v2, tl2, dn2;
    logic [RA-1:0]            row2;
    logic signed [SW-1:0]     sum_c [LANES];
    logic signed [SW-1:0]     sum2  [LANES];

    logic [OUT_W-2:0]         lane_mag [LANES];
    logic [LANES*OUT_W-1:0]   out_c;
    logic [OUT_W-2:0]         row_max, tile_max, track;

    assign start_ok  = (state == IDLE) && i_start && (i_num_tiles != '0);
    assign accept    = (state == RUN) && i_acc_valid;
    assign row_last  = (row_cnt == RA'(ROWS - 1));
    assign tile_last = (tile_cnt == num_tiles_q - TILE_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_coef_we && state == IDLE) begin
            if (i_coef_sel) bias_mem[i_coef_addr]  <= i_coef_data;
            else            scale_mem[i_coef_addr] <= i_coef_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = RUN;
            RUN:     if (accept && row_last && tile_last) state_nx = DRAIN;
            DRAIN:   if (o_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state != IDLE);
        o_ready = (state == RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_tiles_q <= '0;
            relu_q      <= 1'b0;
            round_q     <= 1'b0;
            row_cnt     <= '0;
            tile_cnt    <= '0;
        end else if (start_ok) begin
            num_tiles_q <= i_num_tiles;
            relu_q      <= i_relu_en;
            round_q     <= i_round_en;
            row_cnt     <= '0;
            tile_cnt    <= '0;
        end else if (accept) begin
            if (row_last) begin
                row_cnt  <= '0;
                tile_cnt <= tile_last ? '0 : tile_cnt + TILE_W'(1);
            end else begin
                row_cnt  <= row_cnt + RA'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            prod_c[k] = PW'($signed(scale_mem[row_cnt][k*COEF_W +: COEF_W]))
                      * PW'($signed(i_acc_data[k*ACC_W +: ACC_W]));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1 <= 1'b0; tl1 <= 1'b0; dn1 <= 1'b0; row1 <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                prod1[k] <= '0;
                bias1[k] <= '0;
            end
        end else begin
            v1 <= accept;
            if (accept) begin
                tl1  <= row_last;
                dn1  <= row_last && tile_last;
                row1 <= row_cnt;
                for (int unsigned k = 0; k < LANES; k++) begin
                    prod1[k] <= prod_c[k];
                    bias1[k] <= bias_mem[row_cnt][k*COEF_W +: COEF_W];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            sum_c[k] = {prod1[k][PW-1], prod1[k]}
                     + {{(SW-COEF_W){bias1[k][COEF_W-1]}}, bias1[k]};
            if (relu_q && sum_c[k][SW-1]) sum_c[k] = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2 <= 1'b0; tl2 <= 1'b0; dn2 <= 1'b0; row2 <= '0;
            for (int unsigned k = 0; k < LANES; k++) sum2[k] <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                tl2  <= tl1;
                dn2  <= dn1;
                row2 <= row1;
                for (int unsigned k = 0; k < LANES; k++) sum2[k] <= sum_c[k];
            end
        end
    end

    // Sign-magnitude path keeps rounding symmetric and never yields -2^(OUT_W-1).
    always_comb begin : s3_comb
        logic             neg;
        logic [SW:0]      mag;
        logic [SW:0]      rnd;
        logic [SW:0]      shd;
        logic [OUT_W-1:0] lane;
        neg     = 1'b0;
        mag     = '0;
        rnd     = '0;
        shd     = '0;
        lane    = '0;
        out_c   = '0;
        row_max = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            neg = sum2[k][SW-1];
            mag = {1'b0, neg ? -sum2[k] : sum2[k]};
            rnd = round_q ? mag + HALF : mag;
            shd = rnd >> FRAC;
            if (shd > SAT) shd = SAT;
            lane_mag[k] = shd[OUT_W-2:0];
            lane = {1'b0, shd[OUT_W-2:0]};
            out_c[k*OUT_W +: OUT_W] = neg ? -lane : lane;
            if (shd[OUT_W-2:0] > row_max) row_max = shd[OUT_W-2:0];
        end
        tile_max = (track > row_max) ? track : row_max;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_valid  <= 1'b0;
            o_data        <= '0;
            o_row_idx     <= '0;
            o_tile_done   <= 1'b0;
            o_done        <= 1'b0;
            o_tile_absmax <= '0;
            track         <= '0;
        end else begin
            o_data_valid <= v2;
            o_tile_done  <= v2 && tl2;
            o_done       <= v2 && dn2;
            if (v2) begin
                o_data        <= out_c;
                o_row_idx     <= row2;
                o_tile_absmax <= tile_max;
                track         <= tl2 ? '0 : tile_max;
            end
        end
    end

endmodule

// File: tb/tb_ppu_stream.sv
// Directed bench for ppu_stream: reference model feeds a scoreboard queue at acceptance,
// a negedge monitor pops and checks output rows, latency, pulses and tile absmax.
module tb_ppu_stream;

    localparam int LANES  = 16;
    localparam int ACC_W  = 24;
    localparam int COEF_W = 16;
    localparam int FRAC   = 10;
    localparam int OUT_W  = 18;
    localparam int ROWS   = 16;
    localparam int TILE_W = 8;
    localparam int RA     = 4;
    localparam int DW     = LANES * OUT_W;

    logic                    clk, rst_n;
    logic                    i_coef_we, i_coef_sel;
    logic [RA-1:0]           i_coef_addr;
    logic [LANES*COEF_W-1:0] i_coef_data;
    logic                    i_start;
    logic [TILE_W-1:0]       i_num_tiles;
    logic                    i_relu_en, i_round_en, i_acc_valid;
    logic [LANES*ACC_W-1:0]  i_acc_data;
    logic                    o_busy, o_ready, o_data_valid, o_tile_done, o_done;
    logic [DW-1:0]           o_data;
    logic [RA-1:0]           o_row_idx;
    logic [OUT_W-2:0]        o_tile_absmax;

    ppu_stream #(
        .LANES(LANES), .ACC_W(ACC_W), .COEF_W(COEF_W), .FRAC(FRAC),
        .OUT_W(OUT_W), .ROWS(ROWS), .TILE_W(TILE_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_coef_we(i_coef_we), .i_coef_sel(i_coef_sel),
        .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
        .i_start(i_start), .i_num_tiles(i_num_tiles),
        .i_relu_en(i_relu_en), .i_round_en(i_round_en),
        .i_acc_valid(i_acc_valid), .i_acc_data(i_acc_data),
        .o_busy(o_busy), .o_ready(o_ready), .o_data_valid(o_data_valid),
        .o_data(o_data), .o_row_idx(o_row_idx), .o_tile_done(o_tile_done),
        .o_tile_absmax(o_tile_absmax), .o_done(o_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        bit            tdone;
        bit            done;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total, bad, cyc, rows_seen, dones_seen, exp_max;
    int   sc_m [ROWS][LANES];
    int   bi_m [ROWS][LANES];
    int   m_row, m_tile, m_ntiles;
    bit   m_relu, m_round, m_running;
    int   r0, d0, guard, sent;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model(int s, int b, int a, bit relu, bit rnd);
        longint v, m, q;
        longint unit, maxo;
        unit = longint'(1) << FRAC;
        maxo = (longint'(1) << (OUT_W - 1)) - 1;
        v = longint'(s) * longint'(a) + longint'(b);
        if (relu && v < 0) v = 0;
        m = (v < 0) ? -v : v;
        q = m / unit;
        if (rnd && (m % unit) >= unit / 2) q++;
        if (q > maxo) q = maxo;
        return (v < 0) ? -int'(q) : int'(q);
    endfunction

    function automatic logic [LANES*ACC_W-1:0] row_of(int a0, int a1);
        logic [LANES*ACC_W-1:0] d;
        int v;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            v = (k % 2 == 0) ? a0 : a1;
            d[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
        end
        return d;
    endfunction

    function automatic logic [LANES*ACC_W-1:0] rand_row();
        logic [LANES*ACC_W-1:0] d;
        int v;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            v = int'($urandom_range(0, 524288)) - 262144;
            d[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input bit sel, input int addr, input logic [LANES*COEF_W-1:0] d,
                            input bit apply);
        i_coef_we   = 1'b1;
        i_coef_sel  = sel;
        i_coef_addr = addr[RA-1:0];
        i_coef_data = d;
        tick();
        i_coef_we = 1'b0;
        if (apply) begin
            for (int k = 0; k < LANES; k++) begin
                if (sel) bi_m[addr][k] = $signed(d[k*COEF_W +: COEF_W]);
                else     sc_m[addr][k] = $signed(d[k*COEF_W +: COEF_W]);
            end
        end
    endtask

    task automatic load_all(input bit sel, input int v);
        logic [LANES*COEF_W-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*COEF_W +: COEF_W] = v[COEF_W-1:0];
        for (int r = 0; r < ROWS; r++) load_row(sel, r, d, 1'b1);
    endtask

    task automatic load_random();
        logic [LANES*COEF_W-1:0] s, b;
        int v;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < LANES; k++) begin
                v = int'($urandom_range(0, 8191)) - 4096;
                s[k*COEF_W +: COEF_W] = v[COEF_W-1:0];
                v = int'($urandom_range(0, 65535)) - 32768;
                b[k*COEF_W +: COEF_W] = v[COEF_W-1:0];
            end
            load_row(1'b0, r, s, 1'b1);
            load_row(1'b1, r, b, 1'b1);
        end
    endtask

    task automatic start_run(input int nt, input bit relu, input bit rnd);
        bit take;
        take        = !m_running && (nt != 0);
        i_start     = 1'b1;
        i_num_tiles = nt[TILE_W-1:0];
        i_relu_en   = relu;
        i_round_en  = rnd;
        tick();
        i_start = 1'b0;
        if (take) begin
            m_ntiles  = nt;
            m_relu    = relu;
            m_round   = rnd;
            m_row     = 0;
            m_tile    = 0;
            m_running = 1'b1;
        end
    endtask

    task automatic send_row(input logic [LANES*ACC_W-1:0] d, input bit valid);
        exp_t e;
        int   a, x;
        i_acc_valid = valid;
        i_acc_data  = d;
        if (valid) begin
            chk("ready", o_ready, m_running);
            if (m_running) begin
                e.data = '0;
                for (int k = 0; k < LANES; k++) begin
                    a = $signed(d[k*ACC_W +: ACC_W]);
                    x = model(sc_m[m_row][k], bi_m[m_row][k], a, m_relu, m_round);
                    e.data[k*OUT_W +: OUT_W] = x[OUT_W-1:0];
                end
                e.row   = m_row;
                e.tdone = (m_row == ROWS - 1);
                e.done  = e.tdone && (m_tile == m_ntiles - 1);
                e.cyc   = cyc + 3;
                sb.push_back(e);
                if (e.tdone) begin
                    m_row = 0;
                    m_tile++;
                end else begin
                    m_row++;
                end
                if (e.done) m_running = 1'b0;
            end
        end
        tick();
        i_acc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_reached", o_busy, 1'b0);
        tick();
        chk("queue_drained", sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   o_busy,        '0);
        chk({tag, "_ready"},  o_ready,       '0);
        chk({tag, "_valid"},  o_data_valid,  '0);
        chk({tag, "_data"},   o_data,        '0);
        chk({tag, "_row"},    o_row_idx,     '0);
        chk({tag, "_tdone"},  o_tile_done,   '0);
        chk({tag, "_done"},   o_done,        '0);
        chk({tag, "_absmax"}, o_tile_absmax, '0);
    endtask

    always @(negedge clk) begin
        if (o_data_valid) begin
            rows_seen++;
            if (o_done) dones_seen++;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL spurious_row: got row_idx %0d expected no output", o_row_idx);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("data",      o_data,      mon_e.data);
                chk("row_idx",   o_row_idx,   mon_e.row);
                chk("tile_done", o_tile_done, mon_e.tdone);
                chk("done",      o_done,      mon_e.done);
                chk("latency",   cyc,         mon_e.cyc);
                for (int k = 0; k < LANES; k++) begin
                    int v;
                    v = $signed(mon_e.data[k*OUT_W +: OUT_W]);
                    if (v < 0) v = -v;
                    if (v > exp_max) exp_max = v;
                end
                if (mon_e.tdone) begin
                    chk("tile_absmax", o_tile_absmax, exp_max);
                    exp_max = 0;
                end
            end
        end else begin
            chk("pulse_gating", {o_tile_done, o_done}, '0);
        end
    end

    initial begin
        total = 0; bad = 0; cyc = 0; rows_seen = 0; dones_seen = 0; exp_max = 0;
        m_running = 1'b0; m_row = 0; m_tile = 0; m_ntiles = 0; m_relu = 1'b0; m_round = 1'b0;
        rst_n = 1'b0;
        i_coef_we = 1'b0; i_coef_sel = 1'b0; i_coef_addr = '0; i_coef_data = '0;
        i_start = 1'b0; i_num_tiles = '0; i_relu_en = 1'b0; i_round_en = 1'b0;
        i_acc_valid = 1'b0; i_acc_data = '0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Unity scale, zero bias, single tile
        load_all(1'b0, 1024);
        load_all(1'b1, 0);
        d0 = dones_seen;
        start_run(1, 1'b0, 1'b1);
        for (int r = 0; r < ROWS; r++) send_row(row_of(5, 5), 1'b1);
        wait_idle();
        chk("unity_done_count", dones_seen - d0, 1);

        // Rounding vs truncation on +/-1.5
        load_all(1'b0, 512);
        start_run(1, 1'b0, 1'b1);
        for (int r = 0; r < ROWS; r++) send_row(row_of(3, -3), 1'b1);
        wait_idle();
        start_run(1, 1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++) send_row(row_of(3, -3), 1'b1);
        wait_idle();

        // Bias-only half rounds up
        load_all(1'b0, 0);
        load_all(1'b1, 512);
        start_run(1, 1'b0, 1'b1);
        for (int r = 0; r < ROWS; r++) send_row(row_of(7, -9), 1'b1);
        wait_idle();

        // Saturation at both extremes
        load_all(1'b0, 32767);
        load_all(1'b1, 0);
        start_run(1, 1'b0, 1'b1);
        for (int r = 0; r < ROWS; r++) send_row(row_of(8388607, -8388608), 1'b1);
        wait_idle();

        // ReLU on and off
        load_all(1'b0, 1024);
        load_all(1'b1, -2048);
        start_run(1, 1'b1, 1'b1);
        for (int r = 0; r < ROWS; r++) send_row(row_of(1, 1), 1'b1);
        wait_idle();
        start_run(1, 1'b0, 1'b1);
        for (int r = 0; r < ROWS; r++) send_row(row_of(1, 1), 1'b1);
        wait_idle();

        // Three tiles, random coefficients, bubbles, ignored start/coef write mid-run
        load_random();
        r0 = rows_seen;
        d0 = dones_seen;
        start_run(3, 1'b0, 1'b1);
        guard = 0;
        sent  = 0;
        while (m_running && guard < 2000) begin
            if (sent == 20) begin
                start_run(2, 1'b1, 1'b0);
                load_row(1'b0, 3, '0, 1'b0);
                load_row(1'b1, 4, '1, 1'b0);
                sent++;
            end
            if ($urandom_range(0, 3) == 0) begin
                send_row(rand_row(), 1'b0);
            end else begin
                send_row(rand_row(), 1'b1);
                sent++;
            end
            guard++;
        end
        wait_idle();
        chk("multi_row_count",  rows_seen - r0, 48);
        chk("multi_done_count", dones_seen - d0, 1);

        // Zero tile count leaves the unit idle
        start_run(0, 1'b0, 1'b1);
        tick();
        chk("zero_tiles_busy",  o_busy,  1'b0);
        chk("zero_tiles_ready", o_ready, 1'b0);

        // Reset in the middle of a tile
        start_run(2, 1'b0, 1'b1);
        for (int r = 0; r < 7; r++) send_row(rand_row(), 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        sb.delete();
        exp_max   = 0;
        m_running = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", o_busy, 1'b0);

        // Coefficients survive reset
        start_run(1, 1'b0, 1'b1);
        for (int r = 0; r < ROWS; r++) send_row(rand_row(), 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppu_stream.md
Name: ppu_stream

Overview:
- Parametrised, pipelined post-processing unit. Sits between the systolic-array accumulator drain and the quantiser/softmax stage.
- Applies, per lane and per row:
  - a loadable per-row-per-lane scale (signed, FRAC fractional bits)
  - a loadable bias
  - optional ReLU
  - selectable round-half-away or truncate, then symmetric saturation to OUT_W.
- Streams ROWS rows per tile with valid gating, counts tiles up to a run-time limit, and reports a per-tile absolute maximum for downstream quantisation.

Parameters:
LANES, 16, lanes per row (vector width)
ACC_W, 24, signed accumulator input width per lane
COEF_W, 16, signed scale/bias width per lane (Q(COEF_W-FRAC).FRAC)
FRAC, 10, fractional bits of scale and bias; must be >=1
OUT_W, 18, signed output width per lane
ROWS, 16, rows per tile (power of 2)
TILE_W, 8, width of tile-count configuration

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_coef_we  in  1  coefficient write strobe (honoured only in IDLE)
i_coef_sel  in  1  0 = scale store, 1 = bias store
i_coef_addr  in  log2(ROWS)  coefficient row address
i_coef_data  in  LANES*COEF_W  coefficient row, lane k at [k*COEF_W +: COEF_W]
i_start  in  1  run start pulse; configuration latched here
i_num_tiles  in  TILE_W  tiles in this run; 0 = start ignored
i_relu_en  in  1  ReLU enable, latched at start
i_round_en  in  1  1 = round half away from zero, 0 = truncate toward zero; latched at start
i_acc_valid  in  1  input row valid
i_acc_data  in  LANES*ACC_W  accumulator row
o_busy  out  1  high in RUN or DRAIN
o_ready  out  1  high in RUN; a row is accepted when i_acc_valid & o_ready
o_data_valid  out  1  output row valid
o_data  out  LANES*OUT_W  output row
o_row_idx  out  log2(ROWS)  row index of o_data within its tile
o_tile_done  out  1  pulses with the last row of each tile
o_tile_absmax  out  OUT_W-1  max |o_data lane| over the tile; valid when o_tile_done
o_done  out  1  pulses with the last row of the last tile

Behaviour:
- Reset:
  - Every output and every counter is 0; state is IDLE.
  - Coefficient stores are not cleared and hold undefined values until written.
- FSM states IDLE, RUN, DRAIN:
  - IDLE -> RUN on i_start with i_num_tiles != 0.
  - RUN -> DRAIN when the last row of the last tile is accepted.
  - DRAIN -> IDLE the cycle after o_done.
  - i_start outside IDLE is ignored.
  - i_acc_valid outside RUN is ignored.
  - i_coef_we outside IDLE is ignored.
- Counters:
  - row_cnt advances on each accepted row and wraps ROWS-1 -> 0.
  - tile_cnt advances on each wrap.
  - Invalid cycles (bubbles) freeze both counters.
- Coefficients: the coefficient row used for an accepted input row is the row addressed by row_cnt.
- Pipeline, fixed 3-cycle latency from acceptance to o_data_valid, no backpressure:
  - S1: prod = signed scale * signed acc, COEF_W+ACC_W bits.
  - S2:
    - sum = prod + sign-extended bias, COEF_W+ACC_W+1 bits.
    - If relu_en and sum <= 0, sum = 0.
  - S3:
    - mag = |sum|.
    - Round mode: (mag + 2^(FRAC-1)) >> FRAC. Truncate mode: mag >> FRAC.
    - Saturate mag to 2^(OUT_W-1)-1, then reapply the sign. Output is symmetric; -2^(OUT_W-1) is never produced.
- Per-tile statistics:
  - absmax is tracked on S3 output magnitudes.
  - o_tile_absmax presents the max including the last row in the same cycle as o_tile_done.
  - The tracker then clears so the next tile starts from 0 without a gap cycle.
- Single-cycle pulse outputs: o_tile_done, o_done, o_data_valid.
- Reset asserted mid-run aborts the run immediately. No partial o_tile_done or o_done is emitted.
- If i_start arrives in the same cycle as o_done, it is ignored (state is DRAIN).

Test Plan:
- Load scale=1024 and bias=0 on all rows; run 1 tile with acc=5 in all lanes -> 16 rows with o_data lanes = 5, 3-cycle latency, o_tile_done and o_done together on row 15, o_tile_absmax=5.
- Rounding, scale=512:
  - acc=3 -> 2 with round_en=1, 1 with round_en=0.
  - acc=-3 -> -2 with round_en=1, -1 with round_en=0.
  - Bias=512 with scale=0 -> 1 in round mode.
- Saturation, scale=32767 with acc=8388607 and acc=-8388608 -> 131071 and -131071, absmax=131071.
- ReLU: relu_en=1, bias=-2048, scale=1024, acc=1 -> 0; same stimulus with relu_en=0 -> -1.
- Run with num_tiles=3 and random valid bubbles -> exactly 48 output rows, o_row_idx sequence 0..15 three times, o_done once, per-tile absmax correct with no cross-tile carry; i_start mid-run and coefficient writes mid-run have no effect.
- Other boundaries:
  - num_tiles=0 start -> stays IDLE.
  - Reset pulse at row 7 -> all outputs 0, IDLE.
  - A subsequent run produces correct results with the previously loaded coefficients.
